// File: rtl/aes_ctrl_pkg.sv
// Shared constants and FSM state encoding for the AES-256 round sequencer.
package aes_ctrl_pkg;
  localparam int AES_NUM_ROUNDS  = 14;
  localparam int AES_FINAL_ROUND = AES_NUM_ROUNDS - 1;
  localparam int AES_RIDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } aes_state_t;
endpackage

// File: rtl/aes_key_wdog.sv
// Round-key wait watchdog: counts consecutive unacknowledged key requests and
// raises a sticky err flag when the limit is hit; err clears on the next accepted start.
module aes_key_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic waiting,
  input  logic clear,
  input  logic start_acc,
  output logic expire,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle.
  assign expire = waiting && (cnt == LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (clear)        cnt <= '0;
      else if (waiting) cnt <= cnt + CW'(1);

      if (start_acc)    err <= 1'b0;
      else if (expire)  err <= 1'b1;
    end
  end
endmodule

// File: rtl/aes256_round_ctrl.sv
// AES-256 round sequencer: state-register write/select/round index plus key req/ack and output valid/ready.
// Optional key_ack watchdog is built only when AES_CTRL_TIMEOUT_EN is defined.
module aes256_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS     = AES_NUM_ROUNDS,
  parameter int RIDX_W         = AES_RIDX_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic              key_ack,
  input  logic              out_ready,
  output logic              busy,
  output logic              key_req,
  output logic [3:0]        key_idx,
  output logic              state_wr_en,
  output logic              load_sel,
  output logic [RIDX_W-1:0] round,
  output logic              out_valid,
  output logic              err
);
  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NUM_ROUNDS - 1);

  if (((2 ** RIDX_W) < NUM_ROUNDS) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("aes256_round_ctrl: invalid RIDX_W/NUM_ROUNDS/TIMEOUT_CYCLES");
  end

  aes_state_t state, state_nxt;
  logic       start_acc;
  logic       timeout;

  assign busy        = (state != IDLE);
  assign key_req     = (state == LOAD) || (state == ROUND);
  assign load_sel    = (state == LOAD);
  assign out_valid   = (state == DONE);
  assign state_wr_en = key_req && key_ack && !abort;
  // DONE accepts a new block only on the cycle the finished one is taken.
  assign start_acc   = start && !abort &&
                       ((state == IDLE) || ((state == DONE) && out_ready));

`ifdef AES_CTRL_TIMEOUT_EN
  aes_key_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .resetn   (resetn),
    .waiting  (key_req && !key_ack),
    .clear    (key_ack || (state_nxt != state)),
    .start_acc(start_acc),
    .expire   (timeout),
    .err      (err)
  );
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (key_ack) state_nxt = ROUND;
      ROUND:   if (key_ack && (round == LAST)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout || abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_idx <= '0;
      round   <= '0;
    end else if (abort) begin
      round <= '0;
    end else if (start_acc) begin
      key_idx <= '0;
      round   <= '0;
    end else if (timeout || ((state == DONE) && out_ready)) begin
      round <= '0;
    end else if (state_wr_en) begin
      if (state == LOAD) begin
        key_idx <= 4'd1;
        round   <= '0;
      end else if (round != LAST) begin
        key_idx <= key_idx + 4'd1;
        round   <= round + RIDX_W'(1);
      end
    end
  end
endmodule

// File: doc/aes256_round_ctrl.md
Name: aes256_round_ctrl

Overview:
Round sequencer for the AES-256 encryption datapath. It drives the write enable, round index and input select of the 16-byte state register, and obtains one round key per write from the key-expansion unit over a req/ack handshake. It then holds the finished block for the downstream consumer behind a valid/ready handshake. It sits between the top-level command interface, the key schedule and the round datapath.

Parameters:
NUM_ROUNDS, 14, number of main rounds; the final round index is NUM_ROUNDS-1 (13), which has no MixColumns
RIDX_W, 4, width of the round index; must satisfy 2**RIDX_W >= NUM_ROUNDS
TIMEOUT_CYCLES, 255, key_ack watchdog limit; used only with AES_CTRL_TIMEOUT_EN

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  begin one block; sampled only in IDLE, or in DONE on the accept cycle
abort  in  1  synchronous cancel; returns to IDLE
key_ack  in  1  round key for key_idx is valid this cycle
out_ready  in  1  consumer accepts the finished block
busy  out  1  high in LOAD, ROUND and DONE
key_req  out  1  request round key key_idx
key_idx  out  4  round-key index requested, 0..NUM_ROUNDS
state_wr_en  out  1  write strobe to the state register
load_sel  out  1  1 = state register loads plaintext^key0 (initial AddRoundKey)
round  out  RIDX_W  round index presented to the datapath; equals 13 during the final round
out_valid  out  1  finished block is stable in the state register
err  out  1  key watchdog expired (sticky until next start; 0 when the feature is off)

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; busy, key_req, key_idx, state_wr_en, load_sel, round, out_valid and err all 0.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE: start=1 -> LOAD next cycle. key_idx<=0; err<=0.
- LOAD: key_req=1, load_sel=1. When key_ack=1:
  - state_wr_en=1 in the same cycle;
  - key_idx<=1; round<=0; next state ROUND.
- ROUND: key_req=1, load_sel=0. When key_ack=1:
  - state_wr_en=1;
  - if round==NUM_ROUNDS-1 -> DONE;
  - else round<=round+1 and key_idx<=key_idx+1.
- Wait states: key_ack=0 in LOAD or ROUND -> hold state, round and key_idx; state_wr_en=0.
- state_wr_en is always key_req & key_ack & !abort. It is never asserted outside LOAD or ROUND.
- DONE: out_valid=1 and round holds NUM_ROUNDS-1; the datapath register stays frozen.
  - out_valid & out_ready -> IDLE.
  - If start=1 in that same cycle -> LOAD directly (back-to-back, with the same entry actions as IDLE).
- Latency: with key_ack tied high, start is sampled at cycle 0:
  - LOAD in cycle 1;
  - round 0..13 in cycles 2..15;
  - out_valid first high in cycle 16.
  - 15 state_wr_en pulses in total.
- start while busy (outside the DONE accept cycle): ignored.
- abort has priority over all other inputs: next state IDLE, state_wr_en suppressed that cycle, out_valid drops next cycle, round<=0.
- Reset mid-operation: immediate return to the reset values; no partial output.
- key_ack outside LOAD or ROUND is ignored.
- round never exceeds NUM_ROUNDS-1; no wrap-around.

Optional Feature:
AES_CTRL_TIMEOUT_EN:
- Defined: a counter increments on every cycle with key_req=1 and key_ack=0, and clears on key_ack or on a state change. Reaching TIMEOUT_CYCLES sets err=1 and forces IDLE. err stays high until the next accepted start.
- Undefined: no counter is built, err is tied to 0, and waiting for key_ack is unbounded.

Decomposition:
- Package aes_ctrl_pkg: the state enum (IDLE, LOAD, ROUND, DONE), AES_NUM_ROUNDS=14, AES_FINAL_ROUND=13, the round-index width constant.
- Optional sub-module aes_key_wdog: the watchdog counter plus the err flag, instantiated only under AES_CTRL_TIMEOUT_EN.

Test Plan:
1. key_ack=1 constantly; start pulse at cycle 0 -> load_sel=1 with state_wr_en at cycle 1; round 0..13 at cycles 2..15; out_valid=1 at cycle 16; exactly 15 write strobes.
2. key_ack low for 3 cycles during round 5 -> round and key_idx hold at 5/6, state_wr_en=0 for those 3 cycles; completion shifts by 3 cycles (out_valid at cycle 19).
3. out_ready=0 for 10 cycles in DONE -> out_valid held, no state_wr_en; out_ready=1 together with start -> LOAD next cycle, key_idx=0.
4. abort asserted during round 7 while key_ack=1 -> no write that cycle; IDLE next cycle; round=0, out_valid=0.
5. resetn pulsed low during round 10 -> all outputs are 0 immediately; a fresh start after release completes normally.
6. With AES_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, key_ack=0 in LOAD -> err=1 after 8 waiting cycles, then IDLE; err clears on the next start.
